uart_alu_ctrl: RTL
==================

# uart_alu_ctrl

Frame controller between the UART receiver/transmitter pair and the ALU. It collects a three-byte command frame from the receiver (operand A, operand B, opcode) and presents it atomically to the ALU. It then captures the ALU result and hands it to the transmitter with a single-cycle start pulse, holding off new frames until transmission completes.

## Interface
Parameters:
- `NB_DATA`, default 8: UART byte width; also the ALU operand and result width.
- `NB_OP`, default 6: ALU opcode width. Taken from the low bits of the opcode byte.
- `TIMEOUT_TICKS`, default 704: inter-byte timeout in baud ticks (four 11-bit frames at 16 ticks/bit). Only used with `UART_ALU_CTRL_TIMEOUT_EN`.

Ports:
- `clk`, input, 1: system clock; all logic on rising edge.
- `i_rst_n`, input, 1: reset, asynchronous and active-low.
- `i_tick`, input, 1: baud-rate tick (16x oversample), one `clk` wide.
- `i_rx_data`, input, NB_DATA: received byte; valid when `i_rx_done`=1.
- `i_rx_done`, input, 1: one-cycle pulse, byte received.
- `i_tx_done`, input, 1: one-cycle pulse, transmitter finished its byte.
- `i_alu_result`, input, NB_DATA: combinational ALU result.
- `o_alu_a`, output, NB_DATA: ALU operand A.
- `o_alu_b`, output, NB_DATA: ALU operand B.
- `o_alu_op`, output, NB_OP: ALU opcode.
- `o_tx_data`, output, NB_DATA: byte to transmit.
- `o_tx_start`, output, 1: one-cycle transmit request.
- `o_busy`, output, 1: high from frame commit until `i_tx_done`.

## Operation
- **State register.** States are WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX. Reset state is WAIT_A.
- **WAIT_A.** On `i_rx_done`, load `i_rx_data` into the shadow register `a_q`, then go to WAIT_B.
- **WAIT_B.** On `i_rx_done`, load `i_rx_data` into `b_q`, then go to WAIT_OP.
- **WAIT_OP.** On `i_rx_done`, commit all three values on the same edge and go to EXEC:
  - `o_alu_a` ← `a_q`
  - `o_alu_b` ← `b_q`
  - `o_alu_op` ← `i_rx_data[NB_OP-1:0]`
- **EXEC.** Lasts one cycle, unconditionally. Captures `o_tx_data` ← `i_alu_result`, then goes to SEND.
- **SEND.** Lasts one cycle. `o_tx_start` = 1, then go to WAIT_TX. An `i_tx_done` arriving in SEND is ignored.
- **WAIT_TX.** On `i_tx_done`, go to WAIT_A.
- **Registered outputs.** All outputs are registered. `o_busy` = 1 exactly in EXEC, SEND and WAIT_TX.
- **ALU inputs.** `o_alu_a`, `o_alu_b` and `o_alu_op` change only at commit and hold between frames. Partial frames never reach the ALU.
- **Dropped bytes.** `i_rx_done` in EXEC, SEND or WAIT_TX is dropped, and so is its byte.
  - If `i_rx_done` and `i_tx_done` arrive together in WAIT_TX, go to WAIT_A and drop the byte.
- **Reset.** Asynchronous reset mid-frame or mid-transmit forces WAIT_A immediately. Staged bytes are discarded and all outputs are cleared.
- **Tick input.** `i_tick` is ignored except by the timeout counter.

## Timing
- **Reset values.** All outputs are 0: `o_alu_a`, `o_alu_b`, `o_alu_op`, `o_tx_data`, `o_tx_start`, `o_busy`. Shadow registers are 0 and the timeout counter is 0.
- **Edge references.** Let E0 be the edge that samples the opcode's `i_rx_done`.
  - E0: ALU inputs updated, `o_busy` rises.
  - E1: `o_tx_data` valid.
  - E1 to E2: `o_tx_start` is high for exactly one cycle.
- **Latency.** Opcode byte to `o_tx_start` is 2 cycles.
- **Back-to-back frames.** The earliest accepted A byte of the next frame is the edge after `i_tx_done` is sampled.
- **Byte spacing.** Bytes in WAIT_A, WAIT_B and WAIT_OP may arrive on consecutive cycles. Every pulse in those states is accepted.

## Configuration
- **With `UART_ALU_CTRL_TIMEOUT_EN` defined:**
  - A tick counter of width clog2(TIMEOUT_TICKS+1) runs in WAIT_B and WAIT_OP.
  - It clears on every accepted byte and on entry to WAIT_A, and counts `i_tick` pulses.
  - When the count reaches TIMEOUT_TICKS, the next edge goes to WAIT_A and clears `a_q` and `b_q`.
  - If `i_rx_done` coincides with expiry, the byte is accepted and the counter cleared (the byte wins).
- **Without the macro:** no counter exists. WAIT_B and WAIT_OP wait indefinitely.

## Test plan
- **Basic frame.** Send A=0x05, B=0x03, OP=0x20 with an ALU model (0x20 = add) → `o_alu_a`=0x05, `o_alu_b`=0x03, `o_alu_op`=0x20. `o_tx_data`=0x08 and `o_tx_start` high one cycle, 2 clocks after the OP `i_rx_done`. Pulse `i_tx_done` → `o_busy` falls.
- **Back-to-back frames.** Frame (0xFF, 0x01, 0x20), then frame (0x0A, 0x0F, 0x24, AND) sent immediately after `i_tx_done` → results 0x00 then 0x0A. ALU inputs stay at 0xFF/0x01/0x20 until the second opcode is received.
- **Drop while busy.** Inject byte 0x77 during WAIT_TX, then a full frame (0x02, 0x02, 0x20) → 0x77 ignored, result 0x04.
- **Reset mid-frame.** Send A=0x11, B=0x22, then assert `i_rst_n`=0 asynchronously between edges → all outputs 0 immediately. After release, frame (0x01, 0x01, 0x20) → result 0x02.
- **Timeout (macro on).** Send A=0x09, then 704 `i_tick` pulses with no byte → return to WAIT_A. Then send (0x03, 0x04, 0x20) → result 0x07.
- **Timeout boundary and macro off.**
  - Macro on: a byte coincident with tick 704 is accepted.
  - Macro off: the same stimulus, with 0x03 arriving after the gap, is taken as B.

Source files
------------

// File: rtl/uart_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_alu_ctrl
// Purpose  : Collects a three-byte command frame (A, B, opcode) from the UART
//            receiver, commits it atomically to the ALU, captures the result
//            and hands it to the transmitter with a one-cycle start pulse.
//            New frames are held off until the transmitter reports done.
// Options  : UART_ALU_CTRL_TIMEOUT_EN - inter-byte timeout counted in baud
//            ticks; a stalled partial frame is discarded after TIMEOUT_TICKS.
// Revision : 1.0 - initial release
// ============================================================================
module uart_alu_ctrl #(
    parameter int NB_DATA       = 8,
    parameter int NB_OP         = 6,
    parameter int TIMEOUT_TICKS = 704
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_tick,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy
);

    typedef enum logic [2:0] {
        S_WAIT_A  = 3'd0,
        S_WAIT_B  = 3'd1,
        S_WAIT_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_SEND    = 3'd4,
        S_WAIT_TX = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [NB_DATA-1:0] r_a;
    logic [NB_DATA-1:0] r_b;
    logic               w_expire;
    logic               w_partial;

    // Partial frame staged: the only states where the timeout can act.
    assign w_partial = (r_state == S_WAIT_B) || (r_state == S_WAIT_OP);

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    localparam int NB_CNT = $clog2(TIMEOUT_TICKS + 1);

    logic [NB_CNT-1:0] r_cnt;

    // Expiry is a held condition; an arriving byte on the same edge wins.
    assign w_expire = w_partial && (r_cnt == NB_CNT'(TIMEOUT_TICKS));

    // Tick counter: runs only while a partial frame is staged.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!w_partial || i_rx_done || w_expire) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            r_cnt <= r_cnt + NB_CNT'(1);
        end
    end
`else
    localparam int c_unused_timeout = TIMEOUT_TICKS;

    logic w_unused_tick;

    // Without the timeout, baud ticks have no consumer.
    assign w_unused_tick = i_tick;
    assign w_expire      = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_WAIT_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; bytes outside the collecting states are dropped.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_WAIT_A:  if (i_rx_done) w_state_next = S_WAIT_B;
            S_WAIT_B:  begin
                if (i_rx_done)     w_state_next = S_WAIT_OP;
                else if (w_expire) w_state_next = S_WAIT_A;
            end
            S_WAIT_OP: begin
                if (i_rx_done)     w_state_next = S_EXEC;
                else if (w_expire) w_state_next = S_WAIT_A;
            end
            S_EXEC:    w_state_next = S_SEND;
            S_SEND:    w_state_next = S_WAIT_TX;
            S_WAIT_TX: if (i_tx_done) w_state_next = S_WAIT_A;
            default:   w_state_next = S_WAIT_A;
        endcase
    end

    // Shadow staging, atomic commit, result capture and registered flags.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            if (r_state == S_WAIT_A && i_rx_done) begin
                r_a <= i_rx_data;
            end
            if (r_state == S_WAIT_B && i_rx_done) begin
                r_b <= i_rx_data;
            end
            if (w_expire && !i_rx_done) begin
                r_a <= '0;
                r_b <= '0;
            end
            if (r_state == S_WAIT_OP && i_rx_done) begin
                o_alu_a  <= r_a;
                o_alu_b  <= r_b;
                o_alu_op <= i_rx_data[NB_OP-1:0];
            end
            if (r_state == S_EXEC) begin
                o_tx_data <= i_alu_result;
            end
            o_tx_start <= (w_state_next == S_SEND);
            o_busy     <= (w_state_next == S_EXEC) ||
                          (w_state_next == S_SEND) ||
                          (w_state_next == S_WAIT_TX);
        end
    end

endmodule
`default_nettype wire
